// File: rtl/envelope_follower_pkg.sv
// Shared types and constants for the envelope follower.
// Gate FSM encoding and field widths live here.
package envelope_follower_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_HOLD_W = 16;
    localparam int SHIFT_W    = 4;

    // 2'b11 is unused and treated as IDLE by the FSM
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        HOLD   = 2'b10
    } gate_state_e;

endpackage

// File: rtl/envelope_follower_if.sv
// Sample-in / envelope-out bundle of the envelope follower.
// master drives samples, slave is the follower itself.
interface envelope_follower_if #(
    parameter int DATA_W = 16
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] envelope;
    logic              envelope_valid;
    logic              gate;
    logic              trigger;

    modport master (
        output sample_valid, sample,
        input  envelope, envelope_valid, gate, trigger
    );

    modport slave (
        input  sample_valid, sample,
        output envelope, envelope_valid, gate, trigger
    );
endinterface

// File: rtl/envelope_follower_env_smoother.sv
// One-pole attack/release step with a minimum step of 1.
// Result always lies between env and mag, so it never wraps.
module env_smoother
    import envelope_follower_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0]  env,
    input  logic [DATA_W-1:0]  mag,
    input  logic [SHIFT_W-1:0] attack_shift,
    input  logic [SHIFT_W-1:0] release_shift,
    output logic [DATA_W-1:0]  env_next
);

    logic [DATA_W:0] diff;
    logic [DATA_W:0] step;

    // pick direction, shift the gap, force at least one LSB of movement
    always_comb begin
        diff     = '0;
        step     = '0;
        env_next = env;
        if (mag > env) begin
            diff = {1'b0, mag} - {1'b0, env};
            step = diff >> attack_shift;
            if (step == '0) step = {{DATA_W{1'b0}}, 1'b1};
            env_next = env + step[DATA_W-1:0];
        end else if (mag < env) begin
            diff = {1'b0, env} - {1'b0, mag};
            step = diff >> release_shift;
            if (step == '0) step = {{DATA_W{1'b0}}, 1'b1};
            env_next = env - step[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/envelope_follower.sv
// Rectify -> smooth pipeline with a threshold/hysteresis/hold gate.
// Gate and trigger move on the same edge as the envelope update.
module envelope_follower
    import envelope_follower_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int HOLD_W = DEF_HOLD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [SHIFT_W-1:0] attack_shift,
    input  logic [SHIFT_W-1:0] release_shift,
    input  logic [DATA_W-1:0]  threshold,
    input  logic [DATA_W-1:0]  hysteresis,
    input  logic [HOLD_W-1:0]  hold_samples,
    envelope_follower_if.slave bus
);

    logic [DATA_W-1:0] abs_val;
    logic [DATA_W-1:0] mag;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_mag;
    logic [DATA_W-1:0] env_q;
    logic [DATA_W-1:0] env_next;
    logic              ev_q;
    logic              trig_q;
    logic [DATA_W-1:0] off_level;
    logic              update;
    gate_state_e       state, state_n;
    logic [HOLD_W-1:0] cnt, cnt_n;
    logic              trig_n;

    // full-wave rectify; only the most negative sample reaches 0x8000
    always_comb begin
        abs_val = bus.sample[DATA_W-1] ? (~bus.sample + 1'b1) : bus.sample;
        mag     = abs_val[DATA_W-1] ? '1 : {abs_val[DATA_W-2:0], 1'b0};
    end

    // stage 1: magnitude register with its valid bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_mag   <= '0;
        end else if (enable) begin
            s1_valid <= bus.sample_valid;
            if (bus.sample_valid) s1_mag <= mag;
        end
    end

    env_smoother #(.DATA_W(DATA_W)) u_smooth (
        .env           (env_q),
        .mag           (s1_mag),
        .attack_shift  (attack_shift),
        .release_shift (release_shift),
        .env_next      (env_next)
    );

    assign update = s1_valid & enable;

    // gate-off level, floored at zero
    always_comb begin
        off_level = (threshold > hysteresis) ? (threshold - hysteresis) : '0;
    end

    // gate FSM next state, evaluated only on envelope updates
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        trig_n  = 1'b0;
        if (update) begin
            case (state)
                ACTIVE: begin
                    if (env_next < off_level) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                    end
                end
                HOLD: begin
                    if (env_next > threshold)   state_n = ACTIVE;
                    else if (cnt == hold_samples) state_n = IDLE;
                    else                        cnt_n = cnt + 1'b1;
                end
                default: begin
                    if (env_next > threshold) begin
                        state_n = ACTIVE;
                        trig_n  = 1'b1;
                    end
                end
            endcase
        end
    end

    // stage 2 and FSM registers; pulses are cleared while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            env_q  <= '0;
            ev_q   <= 1'b0;
            trig_q <= 1'b0;
        end else if (enable) begin
            state  <= state_n;
            cnt    <= cnt_n;
            trig_q <= trig_n;
            ev_q   <= s1_valid;
            if (s1_valid) env_q <= env_next;
        end else begin
            ev_q   <= 1'b0;
            trig_q <= 1'b0;
        end
    end

    assign bus.envelope       = env_q;
    assign bus.envelope_valid = ev_q & enable;
    assign bus.trigger        = trig_q & enable;
    assign bus.gate           = (state == ACTIVE) || (state == HOLD);

endmodule

// File: tb/tb_envelope_follower.sv
// Bench for envelope_follower: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_envelope_follower;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [3:0]  attack_shift = '0;
    logic [3:0]  release_shift = '0;
    logic [15:0] threshold = '0;
    logic [15:0] hysteresis = '0;
    logic [15:0] hold_samples = '0;

    int n_cmp = 0;
    int n_bad = 0;

    int m_env, m_mag, m_state, m_cnt;
    bit m_s1v, m_ev, m_trig;

    envelope_follower_if #(.DATA_W(16)) bus ();

    envelope_follower #(.DATA_W(16), .HOLD_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .attack_shift  (attack_shift),
        .release_shift (release_shift),
        .threshold     (threshold),
        .hysteresis    (hysteresis),
        .hold_samples  (hold_samples),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    function automatic int mag_of(input logic [15:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        v = 2 * v;
        if (v > 65535) v = 65535;
        return v;
    endfunction

    function automatic int smooth(input int env, input int mag,
                                  input int sa, input int sr);
        int st;
        if (mag > env) begin
            st = (mag - env) / (1 << sa);
            if (st == 0) st = 1;
            return env + st;
        end
        if (mag < env) begin
            st = (env - mag) / (1 << sr);
            if (st == 0) st = 1;
            return env - st;
        end
        return env;
    endfunction

    task automatic model_clear;
        m_env = 0; m_mag = 0; m_state = 0; m_cnt = 0;
        m_s1v = 0; m_ev = 0; m_trig = 0;
    endtask

    // what the follower should do at one clock edge
    task automatic model_edge;
        int en, off;
        if (reset) begin
            model_clear();
        end else if (!enable) begin
            m_ev = 0;
            m_trig = 0;
        end else begin
            m_ev = 0;
            m_trig = 0;
            if (m_s1v) begin
                en = smooth(m_env, m_mag, int'(attack_shift), int'(release_shift));
                off = int'(threshold) - int'(hysteresis);
                if (off < 0) off = 0;
                m_ev = 1;
                if (m_state == 0) begin
                    if (en > int'(threshold)) begin m_state = 1; m_trig = 1; end
                end else if (m_state == 1) begin
                    if (en < off) begin m_state = 2; m_cnt = 0; end
                end else begin
                    if (en > int'(threshold)) m_state = 1;
                    else if (m_cnt == int'(hold_samples)) m_state = 0;
                    else m_cnt++;
                end
                m_env = en;
            end
            m_s1v = bus.sample_valid;
            if (m_s1v) m_mag = mag_of(bus.sample);
        end
    endtask

    task automatic cycle;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.sample_valid = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;
    endtask

    // one sample, then outputs sampled right after its update edge
    task automatic send(input logic [15:0] s);
        bus.sample = s;
        bus.sample_valid = 1'b1;
        cycle();
        bus.sample_valid = 1'b0;
        cycle();
    endtask

    task automatic gate_setup;
        threshold = 16'h1000;
        hysteresis = 16'h0400;
        hold_samples = 16'd3;
        attack_shift = 4'd0;
        release_shift = 4'd0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.sample = 16'h4000;
        bus.sample_valid = 1'b1;
        repeat (3) begin
            cycle();
            n_cmp++;
            if (bus.envelope !== 16'h0 || bus.envelope_valid !== 1'b0 ||
                bus.gate !== 1'b0 || bus.trigger !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state: env=%h ev=%b gate=%b trig=%b want 0",
                         bus.envelope, bus.envelope_valid, bus.gate, bus.trigger);
            end
        end
        reset = 1'b0;
        cycle();
        bus.sample_valid = 1'b0;
        n_cmp++;
        if (bus.envelope_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: ev=%b want 0", bus.envelope_valid);
        end
        cycle();
        n_cmp++;
        if (bus.envelope_valid !== 1'b1 || bus.envelope !== 16'h8000) begin
            n_bad++;
            $display("FAIL latency_hit: ev=%b env=%h want 1 8000",
                     bus.envelope_valid, bus.envelope);
        end
        cycle();
        n_cmp++;
        if (bus.envelope_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL valid_pulse: ev=%b want 0", bus.envelope_valid);
        end
    endtask

    task automatic test_saturation;
        attack_shift = 4'd0;
        release_shift = 4'd0;
        send(16'h8000);
        n_cmp++;
        if (bus.envelope !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL saturate: env=%h want ffff", bus.envelope);
        end
        send(16'h0000);
        n_cmp++;
        if (bus.envelope !== 16'h0000) begin
            n_bad++;
            $display("FAIL release_instant: env=%h want 0000", bus.envelope);
        end
    endtask

    task automatic test_min_step;
        int exp_env[4] = '{1, 2, 2, 2};
        do_reset();
        attack_shift = 4'd15;
        release_shift = 4'd0;
        bus.sample = 16'h0001;
        bus.sample_valid = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_cmp++;
            if (bus.envelope !== 16'(exp_env[i]) || bus.envelope_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL min_step[%0d]: env=%h ev=%b want %h 1",
                         i, bus.envelope, bus.envelope_valid, exp_env[i]);
            end
        end
        bus.sample_valid = 1'b0;
        cycle();
    endtask

    task automatic test_gate;
        do_reset();
        gate_setup();
        send(16'h0800);
        n_cmp++;
        if (bus.gate !== 1'b0 || bus.trigger !== 1'b0 || bus.envelope !== 16'h1000) begin
            n_bad++;
            $display("FAIL gate_at_thr: gate=%b trig=%b env=%h want 0 0 1000",
                     bus.gate, bus.trigger, bus.envelope);
        end
        send(16'h0801);
        n_cmp++;
        if (bus.gate !== 1'b1 || bus.trigger !== 1'b1) begin
            n_bad++;
            $display("FAIL gate_open: gate=%b trig=%b want 1 1", bus.gate, bus.trigger);
        end
        cycle();
        n_cmp++;
        if (bus.trigger !== 1'b0 || bus.gate !== 1'b1) begin
            n_bad++;
            $display("FAIL trig_pulse: gate=%b trig=%b want 1 0", bus.gate, bus.trigger);
        end
        send(16'h0600);
        n_cmp++;
        if (bus.gate !== 1'b1 || bus.trigger !== 1'b0) begin
            n_bad++;
            $display("FAIL gate_at_off: gate=%b trig=%b want 1 0", bus.gate, bus.trigger);
        end
        for (int i = 1; i <= 5; i++) begin
            send(16'h05FF);
            n_cmp++;
            if (bus.gate !== (i < 5) || bus.trigger !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_upd[%0d]: gate=%b trig=%b want %b 0",
                         i, bus.gate, bus.trigger, (i < 5));
            end
        end
    endtask

    task automatic test_rearm;
        do_reset();
        gate_setup();
        send(16'h0801);
        send(16'h05FF);
        send(16'h05FF);
        send(16'h1000);
        n_cmp++;
        if (bus.gate !== 1'b1 || bus.trigger !== 1'b0 || bus.envelope !== 16'h2000) begin
            n_bad++;
            $display("FAIL rearm: gate=%b trig=%b env=%h want 1 0 2000",
                     bus.gate, bus.trigger, bus.envelope);
        end
        for (int i = 1; i <= 5; i++) begin
            send(16'h05FF);
            n_cmp++;
            if (bus.gate !== (i < 5) || bus.trigger !== 1'b0) begin
                n_bad++;
                $display("FAIL rearm_hold[%0d]: gate=%b trig=%b want %b 0",
                         i, bus.gate, bus.trigger, (i < 5));
            end
        end
    endtask

    task automatic test_enable_reset;
        do_reset();
        attack_shift = 4'd0;
        release_shift = 4'd0;
        threshold = 16'hFFFF;
        bus.sample = 16'h1234;
        bus.sample_valid = 1'b1;
        cycle();
        enable = 1'b0;
        bus.sample = 16'h7FFF;
        repeat (5) begin
            cycle();
            n_cmp++;
            if (bus.envelope_valid !== 1'b0 || bus.envelope !== 16'h0) begin
                n_bad++;
                $display("FAIL stall: ev=%b env=%h want 0 0000",
                         bus.envelope_valid, bus.envelope);
            end
        end
        enable = 1'b1;
        bus.sample_valid = 1'b0;
        cycle();
        n_cmp++;
        if (bus.envelope_valid !== 1'b1 || bus.envelope !== 16'h2468) begin
            n_bad++;
            $display("FAIL resume: ev=%b env=%h want 1 2468",
                     bus.envelope_valid, bus.envelope);
        end
        bus.sample = 16'h0100;
        bus.sample_valid = 1'b1;
        cycle();
        bus.sample_valid = 1'b0;
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if (bus.envelope !== 16'h0 || bus.envelope_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: env=%h ev=%b want 0000 0",
                     bus.envelope, bus.envelope_valid);
        end
        cycle();
        reset = 1'b0;
        repeat (2) begin
            cycle();
            n_cmp++;
            if (bus.envelope_valid !== 1'b0 || bus.envelope !== 16'h0) begin
                n_bad++;
                $display("FAIL inflight_drop: ev=%b env=%h want 0 0000",
                         bus.envelope_valid, bus.envelope);
            end
        end
    endtask

    task automatic test_random;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i % 64 == 0) begin
                attack_shift = 4'($urandom_range(0, 5));
                release_shift = 4'($urandom_range(0, 5));
                threshold = 16'($urandom_range(0, 16'hFFFF));
                hysteresis = 16'($urandom_range(0, 16'h4000));
                hold_samples = 16'($urandom_range(0, 4));
            end
            enable = ($urandom_range(0, 9) != 0);
            bus.sample_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) bus.sample = 16'($urandom_range(0, 16));
            else bus.sample = 16'($urandom);
            cycle();
            n_cmp++;
            if (bus.envelope !== 16'(m_env)) begin
                n_bad++;
                $display("FAIL rnd_env[%0d]: got %h want %h", i, bus.envelope, m_env);
            end
            n_cmp++;
            if (bus.envelope_valid !== (m_ev && enable)) begin
                n_bad++;
                $display("FAIL rnd_ev[%0d]: got %b want %b", i,
                         bus.envelope_valid, (m_ev && enable));
            end
            n_cmp++;
            if (bus.gate !== (m_state != 0)) begin
                n_bad++;
                $display("FAIL rnd_gate[%0d]: got %b want %b", i, bus.gate, (m_state != 0));
            end
            n_cmp++;
            if (bus.trigger !== (m_trig && enable)) begin
                n_bad++;
                $display("FAIL rnd_trig[%0d]: got %b want %b", i,
                         bus.trigger, (m_trig && enable));
            end
        end
        enable = 1'b1;
        bus.sample_valid = 1'b0;
    endtask

    initial begin
        model_clear();
        bus.sample_valid = 1'b0;
        bus.sample = '0;
        test_reset();
        test_saturation();
        test_min_step();
        test_gate();
        test_rearm();
        test_enable_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
